// File: rtl/sn_gen_arbiter.sv
// sn_gen_arbiter: round-robin front end for one shared stochastic-number
// generator. Grants one requester at a time, latches its operands, pulses the
// generator start/stop, passes the bit-streams back to the owner and reports a
// per-lane ones count at the end of each burst.
module sn_gen_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_LANE = 4,
    parameter int LANE_W   = 4,
    parameter int TIMEOUT  = 4
) (
    input  logic                               i_clk_sn_arb,
    input  logic                               i_rst_n_sn_arb,
    input  logic [NUM_REQ-1:0]                 i_req,
    input  logic [NUM_REQ*NUM_LANE*LANE_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]                 i_abort,
    output logic [NUM_REQ-1:0]                 o_ack,
    output logic [NUM_REQ-1:0]                 o_sn_valid,
    output logic [NUM_LANE-1:0]                o_sn_bit,
    output logic [NUM_REQ-1:0]                 o_done,
    output logic [NUM_LANE*5-1:0]              o_ones_cnt,
    output logic                               o_aborted,
    output logic                               o_err,
    output logic                               o_busy,
    output logic [NUM_LANE*LANE_W-1:0]         o_gen_x_bn,
    output logic                               o_gen_start,
    output logic                               o_gen_stop,
    input  logic                               i_gen_isgen,
    input  logic [NUM_LANE-1:0]                i_gen_sn_bit
);

    localparam int SLICE_W = NUM_LANE * LANE_W;
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = 5;
    // A 16-cycle burst can legally produce at most 15 ones; 16 marks overflow.
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                              state;
    logic [PTR_W-1:0]                    ptr;
    logic [PTR_W-1:0]                    owner;
    logic [SLICE_W-1:0]                  x_bn_q;
    logic [NUM_LANE-1:0][CNT_W-1:0]      ones_cnt;
    logic [NUM_LANE-1:0][CNT_W-1:0]      ones_next;
    logic [TMO_W-1:0]                    tmo_cnt;
    logic                                aborted_q;
    logic                                err_q;
    logic                                stop_q;

    logic [NUM_REQ-1:0][SLICE_W-1:0]     req_slices;
    logic [PTR_W:0]                      cand;
    logic [PTR_W-1:0]                    grant_idx;
    logic                                grant_found;
    logic [NUM_REQ-1:0]                  owner_oh;
    logic                                in_burst;
    logic                                stream_valid;
    logic                                abort_hit;

    // Requester r's operands occupy slice r of the flat input bus.
    assign req_slices = i_req_data;

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && i_req[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Next ones counts: add this cycle's bits, saturating at 16.
    always_comb begin
        ones_next = ones_cnt;
        for (int l = 0; l < NUM_LANE; l++) begin
            if (i_gen_sn_bit[l] && (ones_cnt[l] != CNT_SAT)) begin
                ones_next[l] = ones_cnt[l] + CNT_W'(1);
            end
        end
    end

    assign owner_oh     = NUM_REQ'(1) << owner;
    assign in_burst     = (state == S_WAIT) || (state == S_STREAM);
    assign stream_valid = in_burst && i_gen_isgen;
    // Only the owner may stop the burst, and only the first abort cycle counts.
    assign abort_hit    = in_burst && i_abort[owner] && !aborted_q;

    // Acknowledge is combinational so operands are captured on the grant edge;
    // it is held off during reset so every output reads zero while reset is low.
    assign o_ack = (state == S_IDLE && grant_found && i_rst_n_sn_arb)
                   ? (NUM_REQ'(1) << grant_idx) : '0;

    assign o_sn_valid  = stream_valid ? owner_oh : '0;
    assign o_sn_bit    = i_gen_sn_bit & {NUM_LANE{stream_valid}};
    assign o_done      = (state == S_DONE) ? owner_oh : '0;
    assign o_ones_cnt  = ones_cnt;
    assign o_aborted   = aborted_q && (state == S_DONE);
    assign o_err       = err_q && (state == S_DONE);
    assign o_busy      = (state != S_IDLE);
    assign o_gen_x_bn  = x_bn_q;
    assign o_gen_start = (state == S_START);
    assign o_gen_stop  = stop_q;

    // Arbitration / burst FSM with its counters and registered flags.
    always_ff @(posedge i_clk_sn_arb or negedge i_rst_n_sn_arb) begin
        if (!i_rst_n_sn_arb) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            x_bn_q    <= '0;
            ones_cnt  <= '0;
            tmo_cnt   <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            stop_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        owner  <= grant_idx;
                        x_bn_q <= req_slices[grant_idx];
                        state  <= S_START;
                    end
                end
                S_START: begin
                    ones_cnt  <= '0;
                    tmo_cnt   <= '0;
                    aborted_q <= 1'b0;
                    err_q     <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (abort_hit) begin
                        aborted_q <= 1'b1;
                        stop_q    <= 1'b1;
                    end
                    if (i_gen_isgen) begin
                        ones_cnt <= ones_next;
                        state    <= S_STREAM;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_STREAM: begin
                    if (abort_hit) begin
                        aborted_q <= 1'b1;
                        stop_q    <= 1'b1;
                    end
                    // The cycle where isgen falls carries no valid bits.
                    if (i_gen_isgen) begin
                        ones_cnt <= ones_next;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr   <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_gen_arbiter.sv
// tb_sn_gen_arbiter: directed bench for sn_gen_arbiter with a small behavioural
// generator. Each burst record lists the request pattern, generator behaviour
// and the hand-computed grant, counts, flags and done latency.
module tb_sn_gen_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_LANE = 4;
    localparam int LANE_W   = 4;
    localparam int TIMEOUT  = 4;

    // Per-requester operand lanes (lane 0 in the low nibble).
    // r0: F,0,8,5  r1: 7,3,A,1  r2: 4,E,2,C  r3: 0,B,9,6
    localparam logic [63:0] DATA = 64'h69B0_C2E4_1A37_580F;
    localparam logic [19:0] CNT_R0 = {5'd5,  5'd8,  5'd0,  5'd15};
    localparam logic [19:0] CNT_R1 = {5'd1,  5'd10, 5'd3,  5'd7};
    localparam logic [19:0] CNT_R2 = {5'd12, 5'd2,  5'd14, 5'd4};
    localparam logic [19:0] CNT_R3 = {5'd6,  5'd9,  5'd11, 5'd0};
    // r1 stopped after 7 valid cycles: min(lane, 7).
    localparam logic [19:0] CNT_R1_AB = {5'd1, 5'd7, 5'd3, 5'd7};
    localparam logic [19:0] CNT_SAT   = {5'd16, 5'd16, 5'd16, 5'd16};

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NUM_REQ-1:0]           i_req = '0;
    logic [63:0]                  i_req_data = '0;
    logic [NUM_REQ-1:0]           i_abort = '0;
    logic [NUM_REQ-1:0]           o_ack;
    logic [NUM_REQ-1:0]           o_sn_valid;
    logic [NUM_LANE-1:0]          o_sn_bit;
    logic [NUM_REQ-1:0]           o_done;
    logic [NUM_LANE*5-1:0]        o_ones_cnt;
    logic                         o_aborted;
    logic                         o_err;
    logic                         o_busy;
    logic [NUM_LANE*LANE_W-1:0]   o_gen_x_bn;
    logic                         o_gen_start;
    logic                         o_gen_stop;
    logic                         gen_isgen;
    logic [NUM_LANE-1:0]          gen_bits;

    int n_applied = 0;
    int n_miscompare = 0;
    int cyc = 0;
    int prev_done_cyc = 0;
    int gen_len_cfg = 16;
    logic gen_ones_cfg = 1'b0;
    logic [63:0] data_v;

    typedef struct {
        logic [3:0]  req;
        int          gen_len;      // 0: generator never goes active
        logic        ones;         // generator emits all-ones bits
        logic [3:0]  late_req;     // requests raised 5 cycles into the burst
        int          abort_mode;   // 1: r2 aborts at k=1, owner r1 at k=5..7
        logic [3:0]  exp_ack;
        logic [19:0] exp_cnt;
        logic        exp_aborted;
        logic        exp_err;
        int          exp_lat;
        int          exp_stops;
    } burst_t;

    sn_gen_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_LANE(NUM_LANE),
        .LANE_W  (LANE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk_sn_arb  (clk),
        .i_rst_n_sn_arb(rst_n),
        .i_req         (i_req),
        .i_req_data    (i_req_data),
        .i_abort       (i_abort),
        .o_ack         (o_ack),
        .o_sn_valid    (o_sn_valid),
        .o_sn_bit      (o_sn_bit),
        .o_done        (o_done),
        .o_ones_cnt    (o_ones_cnt),
        .o_aborted     (o_aborted),
        .o_err         (o_err),
        .o_busy        (o_busy),
        .o_gen_x_bn    (o_gen_x_bn),
        .o_gen_start   (o_gen_start),
        .o_gen_stop    (o_gen_stop),
        .i_gen_isgen   (gen_isgen),
        .i_gen_sn_bit  (gen_bits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: lane l emits a 1 in burst cycle k when operand > k.
    function automatic logic [3:0] gen_pattern(input logic [15:0] ops, input int k,
                                               input logic ones);
        logic [3:0] b;
        for (int l = 0; l < 4; l++) begin
            b[l] = ones || (int'(ops[l*4 +: 4]) > k);
        end
        return b;
    endfunction

    int          gen_k;
    logic [15:0] gen_ops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_isgen <= 1'b0;
            gen_bits  <= '0;
            gen_k     <= 0;
            gen_ops   <= '0;
        end else if (o_gen_start && gen_len_cfg > 0) begin
            gen_isgen <= 1'b1;
            gen_k     <= 0;
            gen_ops   <= o_gen_x_bn;
            gen_bits  <= gen_pattern(o_gen_x_bn, 0, gen_ones_cfg);
        end else if (gen_isgen) begin
            if (gen_k == gen_len_cfg - 1 || o_gen_stop) begin
                gen_isgen <= 1'b0;
                gen_bits  <= 4'hF;   // junk while inactive: must be ignored
            end else begin
                gen_k    <= gen_k + 1;
                gen_bits <= gen_pattern(gen_ops, gen_k + 1, gen_ones_cfg);
            end
        end else begin
            gen_bits <= 4'hF;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    function automatic burst_t nominal(input logic [3:0] req, input logic [3:0] ack,
                                       input logic [19:0] cnt);
        burst_t b;
        b.req = req;  b.gen_len = 16;  b.ones = 1'b0;  b.late_req = '0;
        b.abort_mode = 0;  b.exp_ack = ack;  b.exp_cnt = cnt;
        b.exp_aborted = 1'b0;  b.exp_err = 1'b0;  b.exp_lat = 19;  b.exp_stops = 0;
        return b;
    endfunction

    // Run one grant-to-done transaction; samples at negedge + 1.
    task automatic run_burst(input burst_t v, input logic chk_gap);
        int   off;
        int   starts;
        int   start_off;
        int   stops;
        int   done_cyc;
        logic done_seen;
        logic pt_ok;
        logic busy_at1;
        logic [3:0] exp_valid;
        logic [3:0] exp_bits;
        @(negedge clk);
        i_req = v.req;
        i_abort = '0;
        gen_len_cfg = v.gen_len;
        gen_ones_cfg = v.ones;
        #1;
        check("ack", 64'(o_ack), 64'(v.exp_ack));
        if (chk_gap) check("grant_gap", 64'(cyc - prev_done_cyc), 64'd1);
        off = 0; starts = 0; start_off = -1; stops = 0; done_cyc = cyc;
        done_seen = 1'b0; pt_ok = 1'b1; busy_at1 = 1'b0;
        while (!done_seen && off < 40) begin
            @(negedge clk);
            off++;
            if (off == 1) i_req = i_req & ~v.exp_ack;
            if (off == 5) i_req = i_req | v.late_req;
            if (v.abort_mode == 1) begin
                if (off == 3)  i_abort = 4'b0100;
                if (off == 4)  i_abort = 4'b0000;
                if (off == 7)  i_abort = 4'b0010;
                if (off == 10) i_abort = 4'b0000;
            end
            #1;
            if (off == 1) busy_at1 = o_busy;
            if (o_gen_start) begin
                starts++;
                if (start_off < 0) start_off = off;
            end
            if (o_gen_stop) stops++;
            exp_valid = gen_isgen ? v.exp_ack : 4'b0000;
            exp_bits  = gen_isgen ? gen_bits  : 4'b0000;
            if (o_sn_valid !== exp_valid || o_sn_bit !== exp_bits) pt_ok = 1'b0;
            if (o_done != '0) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
        i_abort = '0;
        check("done_seen", 64'(done_seen), 64'd1);
        if (done_seen) begin
            check("done_owner", 64'(o_done), 64'(v.exp_ack));
            check("done_latency", 64'(off), 64'(v.exp_lat));
            check("ones_cnt", 64'(o_ones_cnt), 64'(v.exp_cnt));
            check("aborted", 64'(o_aborted), 64'(v.exp_aborted));
            check("err", 64'(o_err), 64'(v.exp_err));
            check("gen_x_bn", 64'(o_gen_x_bn), 64'(data_v[oh2idx(v.exp_ack)*16 +: 16]));
        end
        check("start_pulses", 64'(starts), 64'd1);
        check("start_offset", 64'(start_off), 64'd1);
        check("busy", 64'(busy_at1), 64'd1);
        check("stop_pulses", 64'(stops), 64'(v.exp_stops));
        check("passthrough", 64'(pt_ok), 64'd1);
        prev_done_cyc = done_cyc;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({o_ack, o_sn_valid, o_sn_bit, o_done, o_ones_cnt, o_aborted, o_err,
                    o_busy, o_gen_x_bn, o_gen_start, o_gen_stop});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        burst_t vecs[9];
        burst_t b;
        logic   bad_in_reset;

        data_v = DATA;
        vecs[0] = nominal(4'b0001, 4'b0001, CNT_R0);   // ptr 0
        vecs[1] = nominal(4'b0011, 4'b0010, CNT_R1);   // ptr 1
        vecs[2] = nominal(4'b0011, 4'b0001, CNT_R0);   // ptr 2: r0 wraps ahead of r1
        vecs[3] = nominal(4'b1100, 4'b0100, CNT_R2);   // ptr 1
        vecs[4] = nominal(4'b1111, 4'b1000, CNT_R3);   // ptr 3
        vecs[5] = nominal(4'b1110, 4'b0010, CNT_R1);   // ptr 0
        vecs[6] = nominal(4'b1000, 4'b1000, 20'd0);    // ptr 2, generator dead
        vecs[6].gen_len = 0;  vecs[6].exp_err = 1'b1;  vecs[6].exp_lat = 6;
        vecs[7] = nominal(4'b1001, 4'b0001, CNT_R0);   // ptr advanced to 0 after timeout
        vecs[8] = nominal(4'b0010, 4'b0010, CNT_SAT);  // 18 all-ones cycles saturate
        vecs[8].gen_len = 18;  vecs[8].ones = 1'b1;  vecs[8].exp_lat = 21;

        i_req_data = DATA;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_burst(vecs[i], i != 0);

        // Owner r1 aborts after 5 valid cycles; r2's earlier abort is ignored.
        b = nominal(4'b0010, 4'b0010, CNT_R1_AB);      // ptr 2
        b.abort_mode = 1;  b.exp_aborted = 1'b1;  b.exp_lat = 10;  b.exp_stops = 1;
        run_burst(b, 1'b1);

        // Reset mid-STREAM while r2 keeps requesting.
        @(negedge clk);
        i_req = 4'b0100;
        gen_len_cfg = 16;
        gen_ones_cfg = 1'b0;
        #1;
        check("rst_seq_ack", 64'(o_ack), 64'(4'b0100));
        repeat (5) @(negedge clk);
        #1;
        check("rst_seq_streaming", 64'(o_sn_valid), 64'(4'b0100));
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", all_outputs(), 64'd0);
        bad_in_reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (all_outputs() != 64'd0) bad_in_reset = 1'b1;
        end
        check("quiet_in_reset", 64'(bad_in_reset), 64'd0);
        i_req = '0;
        rst_n = 1'b1;

        // All four hold requests: grants 0,1,2,3 back to back, then r0 again.
        run_burst(nominal(4'b1111, 4'b0001, CNT_R0), 1'b0);
        run_burst(nominal(4'b1110, 4'b0010, CNT_R1), 1'b1);
        run_burst(nominal(4'b1100, 4'b0100, CNT_R2), 1'b1);
        b = nominal(4'b1000, 4'b1000, CNT_R3);
        b.late_req = 4'b0001;
        run_burst(b, 1'b1);
        run_burst(nominal(4'b0011, 4'b0001, CNT_R0), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
